// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, drives the instruction
//               memory request, parks an unconsumed instruction in a one-entry
//               hold buffer while decode is stalled, and owns the IF/ID
//               pipeline register. Optional performance counters are built
//               when the FETCH_PERF_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                   PC_W      = 8,
    parameter int                   INSTR_W   = 32,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write,
    input  logic                IFID_write,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_ready,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     IFID_pc,
    output logic [INSTR_W-1:0]  IFID_instr,
    output logic                IFID_valid,
    output logic [4:0]          ID_rs,
    output logic [4:0]          ID_rt,
    output logic                fetch_wait
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         perf_stall_cnt,
    output logic [15:0]         perf_wait_cnt
`endif
);

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PC_W-1:0]        r_pc;
    logic [PC_W-1:0]        r_hold_pc;
    logic [INSTR_W-1:0]     r_hold_instr;
    logic [PC_W-1:0]        r_ifid_pc;
    logic [INSTR_W-1:0]     r_ifid_instr;
    logic                   r_ifid_valid;

    logic                   w_avail;
    logic [INSTR_W-1:0]     w_avail_instr;
    logic [PC_W-1:0]        w_avail_pc;
    logic                   w_consume;

    // Select the instruction source: live memory data in FETCH, the buffer in HELD
    always_comb begin
        w_avail       = 1'b0;
        w_avail_instr = r_hold_instr;
        w_avail_pc    = r_hold_pc;
        case (r_state)
            S_FETCH: begin
                w_avail       = imem_ready;
                w_avail_instr = imem_rdata;
                w_avail_pc    = r_pc;
            end
            S_HELD: begin
                w_avail = 1'b1;
            end
            default: begin
                w_avail = 1'b0;
            end
        endcase
    end

    // An instruction leaves the fetch stage only when decode accepts it and no redirect kills it
    assign w_consume = w_avail & IFID_write & ~branch_taken;

    // PC, fetch state and hold buffer; a redirect always wins and drops any parked instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_state      <= S_BOOT;
            r_hold_pc    <= '0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            if (branch_taken) begin
                r_pc <= branch_target;
            end else if (w_consume & pc_write) begin
                r_pc <= r_pc + c_pc_one;
            end

            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_avail & ~IFID_write & ~branch_taken) begin
                        r_hold_instr <= imem_rdata;
                        r_hold_pc    <= r_pc;
                        r_state      <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (branch_taken | IFID_write) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall beats load, otherwise a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (!IFID_write) begin
            r_ifid_valid <= r_ifid_valid;
        end else if (w_avail) begin
            r_ifid_pc    <= w_avail_pc;
            r_ifid_instr <= w_avail_instr;
            r_ifid_valid <= 1'b1;
        end else begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end
    end

    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign imem_req   = (r_state == S_FETCH);
    assign fetch_wait = imem_req & ~imem_ready;
    assign IFID_pc    = r_ifid_pc;
    assign IFID_instr = r_ifid_instr;
    assign IFID_valid = r_ifid_valid;
    assign ID_rs      = r_ifid_instr[25:21];
    assign ID_rt      = r_ifid_instr[20:16];

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_stall_cnt;
    logic [15:0] r_perf_wait_cnt;

    // Saturating counters for decode stall cycles and memory wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= 16'h0000;
            r_perf_wait_cnt  <= 16'h0000;
        end else begin
            if (!IFID_write && (r_perf_stall_cnt != 16'hFFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'h0001;
            end
            if (fetch_wait && (r_perf_wait_cnt != 16'hFFFF)) begin
                r_perf_wait_cnt <= r_perf_wait_cnt + 16'h0001;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_wait_cnt  = r_perf_wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Stimulus drives inputs
//               and a transaction-level reference model pushes the expected
//               post-edge view into a queue; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          PC_W      = 8;
    localparam int          INSTR_W   = 32;
    localparam logic [7:0]  RESET_PC  = 8'h00;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic               clk;
    logic               rst;
    logic               pc_write;
    logic               IFID_write;
    logic               branch_taken;
    logic [7:0]         branch_target;
    logic               imem_req;
    logic [7:0]         imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_ready;
    logic [7:0]         pc;
    logic [7:0]         IFID_pc;
    logic [31:0]        IFID_instr;
    logic               IFID_valid;
    logic [4:0]         ID_rs;
    logic [4:0]         ID_rt;
    logic               fetch_wait;
`ifdef FETCH_PERF_EN
    logic [15:0]        perf_stall_cnt;
    logic [15:0]        perf_wait_cnt;
`endif

    fetch_stage #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .IFID_write    (IFID_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .IFID_pc       (IFID_pc),
        .IFID_instr    (IFID_instr),
        .IFID_valid    (IFID_valid),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .fetch_wait    (fetch_wait)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_wait_cnt (perf_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic        valid;
        logic [7:0]  ifid_pc;
        logic [31:0] instr;
        logic        req;
        logic        chk_ifid_pc;
        logic [15:0] stall_cnt;
        logic [15:0] wait_cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: "have" means the instruction at m_pc is already obtained
    logic        m_boot;
    logic        m_have;
    logic [7:0]  m_pc;
    logic        m_valid;
    logic [7:0]  m_ifid_pc;
    logic [31:0] m_instr;
    logic [15:0] m_stall;
    logic [15:0] m_wait;
    logic [31:0] salt;

    function automatic logic [31:0] memf(input logic [7:0] a);
        return (32'h1000_0000 + {24'h0, a}) ^ (salt * ({24'h0, a} + 32'd1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs at negedge, advance the model, queue the expected post-edge view
    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic bt, input logic [7:0] tgt, input logic rdy);
        logic fetching;
        logic avail;
        logic consume;
        logic chk_pc;
        exp_t e;
        @(negedge clk);
        rst           = r;
        pc_write      = pw;
        IFID_write    = iw;
        branch_taken  = bt;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = (imem_req && rdy) ? memf(imem_addr) : $urandom;

        if (r) begin
            m_boot    = 1'b1;
            m_have    = 1'b0;
            m_pc      = RESET_PC;
            m_valid   = 1'b0;
            m_ifid_pc = 8'h00;
            m_instr   = NOP_INSTR;
            m_stall   = 16'h0;
            m_wait    = 16'h0;
            chk_pc    = 1'b1;
        end else begin
            fetching = !m_boot && !m_have;
            avail    = m_have || (fetching && rdy);
            if (!iw && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (fetching && !rdy && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
            if (bt) begin
                m_valid = 1'b0;
                m_instr = NOP_INSTR;
            end else if (!iw) begin
                m_valid = m_valid;
            end else if (avail) begin
                m_valid   = 1'b1;
                m_instr   = memf(m_pc);
                m_ifid_pc = m_pc;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP_INSTR;
            end
            consume = avail && iw && !bt;
            m_have  = !bt && avail && !iw;
            if (bt) m_pc = tgt;
            else if (consume && pw) m_pc = m_pc + 8'd1;
            m_boot = 1'b0;
            chk_pc = m_valid;
        end
        e.pc          = m_pc;
        e.valid       = m_valid;
        e.ifid_pc     = m_ifid_pc;
        e.instr       = m_instr;
        e.req         = !m_boot && !m_have;
        e.chk_ifid_pc = chk_pc;
        e.stall_cnt   = m_stall;
        e.wait_cnt    = m_wait;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    // Monitor: compare the DUT against the oldest expected view just after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",         {24'h0, pc},         {24'h0, e.pc});
            chk("imem_addr",  {24'h0, imem_addr},  {24'h0, e.pc});
            chk("IFID_valid", {31'h0, IFID_valid}, {31'h0, e.valid});
            chk("IFID_instr", IFID_instr,          e.instr);
            if (e.chk_ifid_pc) chk("IFID_pc", {24'h0, IFID_pc}, {24'h0, e.ifid_pc});
            chk("ID_rs",      {27'h0, ID_rs},      {27'h0, e.instr[25:21]});
            chk("ID_rt",      {27'h0, ID_rt},      {27'h0, e.instr[20:16]});
            chk("imem_req",   {31'h0, imem_req},   {31'h0, e.req});
            chk("fetch_wait", {31'h0, fetch_wait}, {31'h0, e.req & ~imem_ready});
`ifdef FETCH_PERF_EN
            chk("perf_stall_cnt", {16'h0, perf_stall_cnt}, {16'h0, e.stall_cnt});
            chk("perf_wait_cnt",  {16'h0, perf_wait_cnt},  {16'h0, e.wait_cnt});
`endif
        end
    end

    initial begin
        rst           = 1'b1;
        pc_write      = 1'b1;
        IFID_write    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h0;
        salt          = 32'h0;
        m_boot = 1'b1; m_have = 1'b0; m_pc = RESET_PC; m_valid = 1'b0;
        m_ifid_pc = 8'h00; m_instr = NOP_INSTR; m_stall = 16'h0; m_wait = 16'h0;

        // Zero-wait streaming, long enough for the PC to wrap past 0xFF
        do_reset();
        do_reset();
        run(262);

        // Load-use stall while IF/ID holds PC 5
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (m_valid && m_ifid_pc == 8'd5) break;
            run(1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        run(3);

        // Memory wait of three cycles at PC 3
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (m_pc == 8'd3 && !m_boot) break;
            run(1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        run(3);

        // Redirect during a memory wait
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
        run(4);

        // Redirect while an instruction is parked in the hold buffer
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
        run(4);

        // Reset while parked, then reset in the middle of a wait
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        do_reset();
        run(4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        do_reset();
        run(4);

        // Randomised traffic with varied instruction encodings
        salt = $urandom | 32'h1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, bt, iw, pw, rdy;
            r   = ($urandom_range(99) == 0);
            bt  = ($urandom_range(19) == 0);
            iw  = ($urandom_range(4) != 0);
            pw  = ($urandom_range(15) == 0) ? 1'($urandom_range(1)) : iw;
            rdy = ($urandom_range(9) < 7);
            step(r, pw, iw, bt, 8'($urandom), rdy);
        end

`ifdef FETCH_PERF_EN
        // Long stall to saturate the stall counter, then clear it with reset
        do_reset();
        for (int i = 0; i < 70000; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'($urandom_range(1)));
        do_reset();
        run(2);
`endif

        run(3);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
